// File: rtl/lock_xfer_channel_if.sv
// Valid/ready transfer-message link carrying (node, epoch).
// Used on both the grant-facing and accept-facing sides of the channel.
interface lock_xfer_channel_if #(
  parameter int NODE_WIDTH  = 2,
  parameter int EPOCH_WIDTH = 8
);
  logic                   valid;
  logic                   ready;
  logic [NODE_WIDTH-1:0]  node;
  logic [EPOCH_WIDTH-1:0] epoch;

  modport master (
    output valid,
    output node,
    output epoch,
    input  ready
  );

  modport slave (
    input  valid,
    input  node,
    input  epoch,
    output ready
  );
endinterface

// File: rtl/lock_xfer_channel.sv
// In-order transfer-message queue that discards stale epochs,
// null epochs and out-of-range destinations.
module lock_xfer_channel #(
  parameter int DEPTH       = 4,
  parameter int NUM_NODES   = 4,
  parameter int NODE_WIDTH  = 2,
  parameter int EPOCH_WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  lock_xfer_channel_if.slave  in_if,
  lock_xfer_channel_if.master out_if,
  output logic [CW-1:0]       count,
  output logic [7:0]          drop_cnt
);

  localparam int NSLOT = 2 ** NODE_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [NODE_WIDTH:0] NN_C = (NODE_WIDTH+1)'(NUM_NODES);

  logic [NODE_WIDTH-1:0]  mem_node [DEPTH];
  logic [EPOCH_WIDTH-1:0] mem_ep   [DEPTH];
  logic [EPOCH_WIDTH-1:0] hi_ep    [NSLOT];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;

  logic                   empty;
  logic                   stale;
  logic                   push;
  logic                   bad;
  logic                   store;
  logic                   deliver;
  logic                   pop;
  logic [NODE_WIDTH-1:0]  head_node;
  logic [EPOCH_WIDTH-1:0] head_ep;
  logic [1:0]             drops;
  logic [8:0]             drop_sum;

  assign empty     = (count == '0);
  assign head_node = mem_node[rd_ptr];
  assign head_ep   = mem_ep[rd_ptr];
  assign stale     = !empty && (head_ep <= hi_ep[head_node]);

  assign in_if.ready  = (count < DEPTH_C);
  assign out_if.valid = !empty && !stale;
  assign out_if.node  = empty ? '0 : head_node;
  assign out_if.epoch = empty ? '0 : head_ep;

  assign push    = in_if.valid && in_if.ready;
  assign bad     = (in_if.epoch == '0) || ({1'b0, in_if.node} >= NN_C);
  assign store   = push && !bad;
  assign deliver = out_if.valid && out_if.ready;
  assign pop     = deliver || stale;

  // Null/invalid push and stale pop can both land in one cycle.
  assign drops    = {1'b0, push && bad} + {1'b0, stale};
  assign drop_sum = {1'b0, drop_cnt} + {7'b0, drops};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < NSLOT; i++) hi_ep[i] <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (deliver) hi_ep[head_node] <= head_ep;
      unique case ({store, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      drop_cnt <= drop_sum[8] ? 8'hff : drop_sum[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      mem_node[wr_ptr] <= in_if.node;
      mem_ep[wr_ptr]   <= in_if.epoch;
    end
  end

endmodule

// File: tb/tb_lock_xfer_channel.sv
// Directed and random stimulus for lock_xfer_channel against a
// queue-based model of the delivery and discard rules.
module tb_lock_xfer_channel;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] count;
  logic [7:0] drop_cnt;

  always #5 clk = ~clk;

  lock_xfer_channel_if #(.NODE_WIDTH(2), .EPOCH_WIDTH(8)) in_if ();
  lock_xfer_channel_if #(.NODE_WIDTH(2), .EPOCH_WIDTH(8)) out_if ();

  lock_xfer_channel #(
    .DEPTH(4), .NUM_NODES(4), .NODE_WIDTH(2), .EPOCH_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_if    (in_if.slave),
    .out_if   (out_if.master),
    .count    (count),
    .drop_cnt (drop_cnt)
  );

  typedef struct {
    int node;
    int ep;
  } msg_t;

  msg_t q[$];
  int   hi[4];
  int   m_drop;
  int   checks;
  int   errors;
  int   got[$];
  bit   dv;
  int   dn;
  int   de;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    foreach (hi[i]) hi[i] = 0;
    m_drop = 0;
  endtask

  // One clock: drive at negedge, check outputs, advance model at posedge.
  task automatic cycle(input bit iv, input int nd, input int ep,
                       input bit ordy, output bit delivered,
                       output int dnode, output int dep);
    int  ms;
    bit  st;
    bit  ev;
    bit  rdy;
    int  hn;
    int  he;
    in_if.valid  = iv;
    in_if.node   = 2'(nd);
    in_if.epoch  = 8'(ep);
    out_if.ready = ordy;
    #1;
    ms  = q.size();
    hn  = (ms > 0) ? q[0].node : 0;
    he  = (ms > 0) ? q[0].ep : 0;
    st  = (ms > 0) && (he <= hi[hn]);
    ev  = (ms > 0) && !st;
    rdy = (ms < 4);
    chk("in_ready",  32'(in_if.ready),   32'(rdy));
    chk("out_valid", 32'(out_if.valid),  32'(ev));
    chk("out_node",  32'(out_if.node),   32'(hn));
    chk("out_epoch", 32'(out_if.epoch),  32'(he));
    chk("count",     32'(count),         32'(ms));
    chk("drop_cnt",  32'(drop_cnt),      32'(m_drop));
    delivered = ev && ordy;
    dnode = hn;
    dep   = he;
    @(posedge clk);
    if (st) begin
      void'(q.pop_front());
      m_drop++;
    end else if (delivered) begin
      hi[hn] = he;
      void'(q.pop_front());
    end
    if (iv && rdy) begin
      if (ep == 0 || nd >= 4) m_drop++;
      else q.push_back('{node: nd, ep: ep});
    end
    if (m_drop > 255) m_drop = 255;
    @(negedge clk);
  endtask

  task automatic hard_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_in_ready", 32'(in_if.ready), 32'd1);
    chk("rst_out_valid", 32'(out_if.valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_node", 32'(out_if.node), 32'd0);
    chk("rst_out_epoch", 32'(out_if.epoch), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    in_if.valid  = 1'b0;
    in_if.node   = '0;
    in_if.epoch  = '0;
    out_if.ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    hard_reset();

    // Basic push then pop
    cycle(1, 1, 5, 0, dv, dn, de);
    cycle(0, 0, 0, 0, dv, dn, de);
    chk("basic_epoch", 32'(out_if.epoch), 32'd5);
    cycle(0, 0, 0, 1, dv, dn, de);
    chk("basic_deliv", 32'(dv), 32'd1);
    cycle(0, 0, 0, 0, dv, dn, de);
    chk("basic_empty", 32'(count), 32'd0);

    // Fill, refuse, drain, then refill to exercise wrap
    hard_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 5; i++)
        cycle(1, 2, 3 + 4 * k + i, 0, dv, dn, de);
      chk("full_count", 32'(count), 32'd4);
      chk("full_ready", 32'(in_if.ready), 32'd0);
      got.delete();
      for (int i = 0; i < 5; i++) begin
        cycle(0, 0, 0, 1, dv, dn, de);
        if (dv) got.push_back(de);
      end
      chk("drain_n", 32'(got.size()), 32'd4);
      for (int i = 0; i < got.size(); i++)
        chk("drain_ep", 32'(got[i]), 32'(3 + 4 * k + i));
    end

    // Stale filtering for node 0
    hard_reset();
    cycle(1, 0, 9, 0, dv, dn, de);
    cycle(1, 0, 9, 1, dv, dn, de);
    cycle(1, 0, 4, 0, dv, dn, de);
    cycle(1, 0, 12, 0, dv, dn, de);
    got.delete();
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 1, dv, dn, de);
      if (dv) got.push_back(de);
    end
    chk("stale_n", 32'(got.size()), 32'd1);
    chk("stale_ep", 32'(got[0]), 32'd12);
    chk("stale_drops", 32'(drop_cnt), 32'd2);

    // Null epochs, then saturation
    hard_reset();
    cycle(1, 0, 0, 0, dv, dn, de);
    cycle(1, 3, 0, 0, dv, dn, de);
    cycle(0, 0, 0, 0, dv, dn, de);
    chk("null_count", 32'(count), 32'd0);
    chk("null_drops", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 300; i++)
      cycle(1, i % 4, 0, 0, dv, dn, de);
    chk("sat_drops", 32'(drop_cnt), 32'd255);

    // Push+pop on full queue, then at count 2
    hard_reset();
    for (int i = 0; i < 4; i++)
      cycle(1, 3, 10 + i, 0, dv, dn, de);
    cycle(1, 3, 20, 1, dv, dn, de);
    chk("fullpp_count", 32'(count), 32'd3);
    cycle(0, 0, 0, 1, dv, dn, de);
    cycle(1, 3, 21, 1, dv, dn, de);
    chk("pp2_count", 32'(count), 32'd2);

    // Asynchronous reset mid-stream
    hard_reset();
    cycle(1, 1, 7, 0, dv, dn, de);
    cycle(1, 0, 1, 1, dv, dn, de);
    cycle(1, 0, 2, 0, dv, dn, de);
    cycle(1, 0, 3, 0, dv, dn, de);
    cycle(0, 0, 0, 0, dv, dn, de);
    chk("pre_rst_count", 32'(count), 32'd3);
    #2;
    hard_reset();
    cycle(1, 1, 2, 0, dv, dn, de);
    cycle(0, 0, 0, 1, dv, dn, de);
    chk("post_rst_deliv", 32'(dv), 32'd1);
    chk("post_rst_ep", 32'(de), 32'd2);

    // Random traffic against the model
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3),
            $urandom_range(0, 15), $urandom_range(0, 1) == 1,
            dv, dn, de);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
